// File: rtl/bubble_sort_ctrl_if.sv
// Compare-ALU link: the sorter drives operands and opcode, the ALU answers
// with lt/gt/eq flags in the same cycle.
interface bubble_sort_ctrl_if;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [1:0]  alu_op;
  logic        alu_lt;
  logic        alu_gt;
  logic        alu_eq;

  modport master (output alu_op1, alu_op2, alu_op, input alu_lt, alu_gt, alu_eq);
  modport slave  (input alu_op1, alu_op2, alu_op, output alu_lt, alu_gt, alu_eq);
endinterface

// File: rtl/bubble_sort_ctrl.sv
// In-place ascending bubble sort over a DEPTH x 16 register array, using an
// external combinational compare ALU for every ordering decision.
module bubble_sort_ctrl #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cmp_err,
  output logic [15:0]   swap_cnt,
  bubble_sort_ctrl_if.master alu
);

  typedef enum logic [1:0] {IDLE, CMP, SWAP, DONE} state_t;

  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] j;
  logic [AW-1:0] lim;
  logic          swapped;

  logic [AW-1:0] j1;
  logic [AW-1:0] j_next;
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic          flags_ok;
  logic          pass_end;
  logic          finish;
  logic          advance;
  logic [15:0]   op1_next;
  logic [15:0]   op2_next;

  assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

  // Next-step decode. Operands for the upcoming CMP are read as the array
  // will look after this edge, so a same-cycle host write or swap is seen.
  always_comb begin
    j1       = j + AW'(1);
    flags_ok = $onehot({alu.alu_lt, alu.alu_gt, alu.alu_eq});
    pass_end = (j == lim - AW'(1));
    finish   = pass_end && (!(swapped || state == SWAP) || lim == AW'(1));
    advance  = (state == SWAP) || (state == CMP && flags_ok && !alu.alu_gt);
    j_next   = (state == IDLE || pass_end) ? '0 : j1;
    a1       = j_next;
    a2       = j_next + AW'(1);
    op1_next = mem[a1];
    op2_next = mem[a2];
    if (state == IDLE && wr_en) begin
      if (wr_addr == a1) op1_next = wr_data;
      if (wr_addr == a2) op2_next = wr_data;
    end
    if (state == SWAP) begin
      if (a1 == j)       op1_next = mem[j1];
      else if (a1 == j1) op1_next = mem[j];
      if (a2 == j)       op2_next = mem[j1];
      else if (a2 == j1) op2_next = mem[j];
    end
  end

  // Sequencer, array storage and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmp_err     <= 1'b0;
      swap_cnt    <= '0;
      alu.alu_op1 <= '0;
      alu.alu_op2 <= '0;
      alu.alu_op  <= OP_NOP;
      j           <= '0;
      lim         <= '0;
      swapped     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en && int'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
          if (start) begin
            state       <= CMP;
            busy        <= 1'b1;
            j           <= '0;
            lim         <= AW'(DEPTH - 1);
            swapped     <= 1'b0;
            swap_cnt    <= '0;
            cmp_err     <= 1'b0;
            alu.alu_op  <= OP_CMP;
            alu.alu_op1 <= op1_next;
            alu.alu_op2 <= op2_next;
          end
        end
        CMP: begin
          if (!flags_ok) begin
            cmp_err    <= 1'b1;
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            alu.alu_op <= OP_NOP;
          end else if (alu.alu_gt) begin
            state      <= SWAP;
            alu.alu_op <= OP_NOP;
          end
        end
        SWAP: begin
          mem[j]  <= mem[j1];
          mem[j1] <= mem[j];
          swapped <= 1'b1;
          if (swap_cnt != 16'hFFFF) swap_cnt <= swap_cnt + 16'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Shared end-of-compare handling; later assignments override the case.
      if (advance) begin
        if (finish) begin
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          alu.alu_op <= OP_NOP;
        end else begin
          state       <= CMP;
          j           <= j_next;
          alu.alu_op  <= OP_CMP;
          alu.alu_op1 <= op1_next;
          alu.alu_op2 <= op2_next;
          if (pass_end) begin
            lim     <= lim - AW'(1);
            swapped <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl with a behavioural compare ALU that can
// mask tag bits (stability check) or inject illegal flag combinations.
module tb_bubble_sort_ctrl;

  typedef logic [15:0] arr_t [8];

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        start;
  logic        busy;
  logic        done;
  logic        cmp_err;
  logic [15:0] swap_cnt;

  logic        inject = 1'b0;
  logic        tag_mode = 1'b0;
  logic [15:0] ka, kb;

  int checks = 0;
  int errors = 0;

  bubble_sort_ctrl_if alu_bus ();

  bubble_sort_ctrl #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .start(start), .busy(busy), .done(done),
    .cmp_err(cmp_err), .swap_cnt(swap_cnt),
    .alu(alu_bus)
  );

  always #5 clk = ~clk;

  // External ALU: in tag mode only the low 12 bits are the sort key.
  assign ka = tag_mode ? {4'b0, alu_bus.alu_op1[11:0]} : alu_bus.alu_op1;
  assign kb = tag_mode ? {4'b0, alu_bus.alu_op2[11:0]} : alu_bus.alu_op2;
  assign alu_bus.alu_lt = inject | (ka < kb);
  assign alu_bus.alu_gt = inject | (ka > kb);
  assign alu_bus.alu_eq = ~inject & (ka == kb);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input arr_t v);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = v[i];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic checkArray(input string tag, input arr_t exp);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      checkOutput($sformatf("%s[%0d]", tag, i), {16'h0, rd_data}, {16'h0, exp[i]});
    end
  endtask

  // Pulses start (optionally with a same-cycle write) and watches the run;
  // cycle n is the n-th cycle after the edge that sampled start.
  task automatic runSort(input int bad_at, input logic wr_same, input logic [2:0] wa,
                         input logic [15:0] wd, output int done_cyc, output int cmp_cnt,
                         output int busy_cnt, output int bad_op, output logic done_after);
    @(posedge clk); #1;
    start = 1'b1; wr_en = wr_same; wr_addr = wa; wr_data = wd;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    done_cyc = -1; cmp_cnt = 0; busy_cnt = 0; bad_op = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (alu_bus.alu_op == 2'b01) cmp_cnt++;
      inject = (bad_at != 0) && (alu_bus.alu_op == 2'b01) && (cmp_cnt == bad_at);
      if (busy) busy_cnt++;
      if (alu_bus.alu_op == 2'b01 && !busy) bad_op++;
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    inject = 1'b0;
    @(negedge clk);
    done_after = done;
  endtask

  initial begin
    arr_t vec, exp;
    int dc, cc, bc, bo, dpulses;
    logic da;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_cmp_err", {31'h0, cmp_err}, 32'h0);
    checkOutput("rst_swap_cnt", {16'h0, swap_cnt}, 32'h0);
    checkOutput("rst_alu_op", {30'h0, alu_bus.alu_op}, 32'h2);
    checkOutput("rst_alu_op1", {16'h0, alu_bus.alu_op1}, 32'h0);
    exp = '{default: 16'h0};
    checkArray("rst_mem", exp);

    // Nearly sorted; the write landing with start fixes entry 0 before the first compare.
    vec = '{16'd9, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    applyStimulus(vec);
    runSort(0, 1'b1, 3'd0, 16'd1, dc, cc, bc, bo, da);
    checkOutput("sorted_done_cyc", dc, 8);
    checkOutput("sorted_cmp_cnt", cc, 7);
    checkOutput("sorted_busy_cnt", bc, 7);
    checkOutput("sorted_swap_cnt", {16'h0, swap_cnt}, 32'h0);
    checkOutput("sorted_done_width", {31'h0, da}, 32'h0);
    exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    checkArray("sorted_mem", exp);

    vec = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    applyStimulus(vec);
    runSort(0, 1'b0, 3'd0, 16'd0, dc, cc, bc, bo, da);
    checkOutput("rev_done_cyc", dc, 57);
    checkOutput("rev_cmp_cnt", cc, 28);
    checkOutput("rev_busy_cnt", bc, 56);
    checkOutput("rev_op_outside_cmp", bo, 0);
    checkOutput("rev_swap_cnt", {16'h0, swap_cnt}, 32'd28);
    checkOutput("rev_busy_after", {31'h0, busy}, 32'h0);
    checkArray("rev_mem", exp);

    // Keys 5,3,5,1,3,0,9,5 with the original index in the top nibble.
    tag_mode = 1'b1;
    vec = '{16'h0005, 16'h1003, 16'h2005, 16'h3001, 16'h4003, 16'h5000, 16'h6009, 16'h7005};
    applyStimulus(vec);
    runSort(0, 1'b0, 3'd0, 16'd0, dc, cc, bc, bo, da);
    checkOutput("stable_swap_cnt", {16'h0, swap_cnt}, 32'd12);
    exp = '{16'h5000, 16'h3001, 16'h1003, 16'h4003, 16'h0005, 16'h2005, 16'h7005, 16'h6009};
    checkArray("stable_mem", exp);
    tag_mode = 1'b0;

    // Illegal flags on the 3rd compare of a reversed array.
    vec = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    applyStimulus(vec);
    runSort(3, 1'b0, 3'd0, 16'd0, dc, cc, bc, bo, da);
    checkOutput("err_done_cyc", dc, 6);
    checkOutput("err_cmp_err", {31'h0, cmp_err}, 32'h1);
    checkOutput("err_swap_cnt", {16'h0, swap_cnt}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("err_cmp_err_held", {31'h0, cmp_err}, 32'h1);
    exp = '{16'd7, 16'd6, 16'd8, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    checkArray("err_mem", exp);

    runSort(0, 1'b0, 3'd0, 16'd0, dc, cc, bc, bo, da);
    checkOutput("rerun_cmp_err", {31'h0, cmp_err}, 32'h0);
    checkOutput("rerun_swap_cnt", {16'h0, swap_cnt}, 32'd26);
    exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    checkArray("rerun_mem", exp);

    // Write/start while busy are ignored; reset mid-sort aborts silently.
    vec = '{16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    applyStimulus(vec);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hBEEF; start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    rd_addr = 3'd0;
    #1;
    checkOutput("busy_wr_ignored", {16'h0, rd_data}, 32'd7);
    checkOutput("busy_start_ignored", {16'h0, swap_cnt}, 32'd2);
    checkOutput("busy_mid_sort", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_busy", {31'h0, busy}, 32'h0);
    checkOutput("midrst_alu_op", {30'h0, alu_bus.alu_op}, 32'h2);
    dpulses = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done) dpulses++;
    end
    checkOutput("midrst_no_done", dpulses, 0);
    exp = '{default: 16'h0};
    checkArray("midrst_mem", exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
